// File: rtl/dsp_conv_responder.sv
// ----------------------------------------------------------------------------
// dsp_conv_responder
//
// Memory-mapped DSP coprocessor slave. The CPU loads samples, coefficients
// and lengths, writes START, polls STATUS and reads back the signed 1-D
// linear convolution RESULT[n] = sum_k COEF[k] * SAMPLE[n-k], computed by a
// single-MAC FSM (one cycle per tap plus one store cycle per output).
//
// Register map (word offsets):
//   0x00 CTRL   W  bit0 START, bit1 CLEAR (self-clearing, reads 0)
//   0x01 STATUS R  bit0 BUSY, bit1 DONE, bit2 ERR
//   0x02 LEN    RW N, bits[4:0]
//   0x03 TAPS   RW K, bits[3:0]
//   0x10-0x1F SAMPLE[i] RW, 0x20-0x27 COEF[j] RW, 0x28-0x3F RESULT[n] R
//   Anything else reads 0, writes ignored.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   bus_sel      access request, held until bus_ready
//   bus_write_en 1 = write, 0 = read
//   bus_addr     word offset within the DSP window
//   bus_wdata    write data
//   bus_rdata    read data, valid while bus_ready = 1, else 0
//   bus_ready    one-cycle access-complete pulse
//   busy         mirror of STATUS.BUSY
//
// Build option:
//   DSP_CONV_SAT_EN  when defined, STORE saturates the accumulator to the
//                    signed DATA_WIDTH range; otherwise it wraps.
// ----------------------------------------------------------------------------
module dsp_conv_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_SAMPLES = 16,
  parameter int MAX_TAPS    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bus_sel,
  input  logic                  bus_write_en,
  input  logic [5:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_ready,
  output logic                  busy
);

  localparam int SIDX_W    = $clog2(MAX_SAMPLES);
  localparam int CIDX_W    = $clog2(MAX_TAPS);
  localparam int RES_DEPTH = 24;               // 0x28..0x3F
  localparam int ACC_W     = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, STORE, FIN} state_t;

  state_t state_q, state_d;

  logic [4:0]            len_q;
  logic [3:0]            taps_q;
  logic [DATA_WIDTH-1:0] sample_mem [MAX_SAMPLES];
  logic [DATA_WIDTH-1:0] coef_mem   [MAX_TAPS];
  logic [DATA_WIDTH-1:0] result_mem [RES_DEPTH];

  logic [4:0]            n_q;
  logic [3:0]            k_q;
  logic [ACC_W-1:0]      acc_q;
  logic                  done_q;
  logic                  err_q;

  // --------------------------------------------------------------------------
  // Bus decode. An access is taken only while no response is pending, so a
  // held bus_sel during the ready cycle is not taken twice.
  // --------------------------------------------------------------------------
  logic       access, wr, rd;
  logic       is_ctrl, is_status, is_len, is_taps, is_sample, is_coef, is_result;
  logic [4:0] res_idx;
  logic       start_req, clear_req, cfg_wr;

  assign access    = bus_sel && !bus_ready;
  assign wr        = access && bus_write_en;
  assign rd        = access && !bus_write_en;

  assign is_ctrl   = (bus_addr == 6'h00);
  assign is_status = (bus_addr == 6'h01);
  assign is_len    = (bus_addr == 6'h02);
  assign is_taps   = (bus_addr == 6'h03);
  assign is_sample = (bus_addr[5:4] == 2'b01) && ({1'b0, bus_addr[3:0]} < 5'(MAX_SAMPLES));
  assign is_coef   = (bus_addr[5:3] == 3'b100) && ({1'b0, bus_addr[2:0]} < 4'(MAX_TAPS));
  assign is_result = (bus_addr >= 6'h28);
  assign res_idx   = 5'(bus_addr - 6'h28);

  assign start_req = wr && is_ctrl && bus_wdata[0];
  assign clear_req = wr && is_ctrl && bus_wdata[1];
  assign cfg_wr    = wr && (is_len || is_taps || is_sample || is_coef);

  // Run control
  logic       params_ok, start_ok, k_is_last, n_is_last;
  logic [5:0] last_n;

  assign params_ok = (len_q != 5'd0) && (len_q <= 5'(MAX_SAMPLES)) &&
                     (taps_q != 4'd0) && (taps_q <= 4'(MAX_TAPS));
  // FIN is not busy, so a START landing there is treated like one in IDLE.
  assign start_ok  = start_req && params_ok && (state_q == IDLE || state_q == FIN);
  assign last_n    = {1'b0, len_q} + {2'b0, taps_q} - 6'd2;
  assign k_is_last = (k_q == taps_q - 4'd1);
  assign n_is_last = ({1'b0, n_q} == last_n);

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = MAC;
      MAC:     if (k_is_last) state_d = STORE;
      STORE:   state_d = n_is_last ? FIN : MAC;
      FIN:     state_d = start_ok ? MAC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic mac_en, store_en;

  always_comb begin
    busy     = 1'b0;
    mac_en   = 1'b0;
    store_en = 1'b0;
    case (state_q)
      MAC:     begin busy = 1'b1; mac_en   = 1'b1; end
      STORE:   begin busy = 1'b1; store_en = 1'b1; end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // MAC datapath. Terms whose sample index falls outside 0..N-1 contribute 0.
  // Operands are sign-extended so the product is the full signed 2W result.
  // --------------------------------------------------------------------------
  logic [5:0]            diff;
  logic                  term_valid;
  logic [DATA_WIDTH-1:0] s_val, c_val;
  logic [ACC_W-1:0]      prod;
  logic [DATA_WIDTH-1:0] store_val;

  always_comb begin
    diff       = {1'b0, n_q} - {2'b0, k_q};
    term_valid = !diff[5] && (diff[4:0] < len_q);
    s_val      = term_valid ? sample_mem[diff[SIDX_W-1:0]] : '0;
    c_val      = coef_mem[k_q[CIDX_W-1:0]];
    prod       = ACC_W'($signed({{DATA_WIDTH{c_val[DATA_WIDTH-1]}}, c_val}) *
                        $signed({{DATA_WIDTH{s_val[DATA_WIDTH-1]}}, s_val}));
  end

`ifdef DSP_CONV_SAT_EN
  // The value fits when all bits from the sign bit of the narrow result
  // upward agree; otherwise clamp towards the accumulator's sign.
  logic [DATA_WIDTH:0] acc_top;
  assign acc_top = acc_q[ACC_W-1:DATA_WIDTH-1];

  always_comb begin
    if (&acc_top || ~|acc_top)
      store_val = acc_q[DATA_WIDTH-1:0];
    else if (acc_q[ACC_W-1])
      store_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      store_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign store_val = acc_q[DATA_WIDTH-1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // always_ff sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      n_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
    end else if (start_ok) begin
      n_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
    end else if (mac_en) begin
      acc_q <= acc_q + prod;
      k_q   <= k_q + 4'd1;
    end else if (store_en && !n_is_last) begin
      n_q   <= n_q + 5'd1;
      k_q   <= '0;
      acc_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Register file. Configuration is frozen while busy.
  // NOTE: these small buffers are flop arrays and must read as zero after
  // reset, so they are cleared on reset like any other register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      len_q  <= '0;
      taps_q <= '0;
      for (int i = 0; i < MAX_SAMPLES; i++) sample_mem[i] <= '0;
      for (int i = 0; i < MAX_TAPS; i++)    coef_mem[i]   <= '0;
      for (int i = 0; i < RES_DEPTH; i++)   result_mem[i] <= '0;
    end else begin
      if (cfg_wr && !busy) begin
        if (is_len)    len_q  <= bus_wdata[4:0];
        if (is_taps)   taps_q <= bus_wdata[3:0];
        if (is_sample) sample_mem[bus_addr[SIDX_W-1:0]] <= bus_wdata;
        if (is_coef)   coef_mem[bus_addr[CIDX_W-1:0]]   <= bus_wdata;
      end
      if (store_en) result_mem[n_q] <= store_val;
    end
  end

  // Status flags. CLEAR is applied first, so a CLEAR+START write ends with
  // the flags produced by the START evaluation.
  always_ff @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (clear_req) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (store_en && n_is_last) done_q <= 1'b1;
      if (start_req) begin
        if (busy || !params_ok) begin
          err_q <= 1'b1;
        end else begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
      end
      if (cfg_wr && busy) err_q <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and bus response
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (is_status)      rd_val[2:0] = {err_q, done_q, busy};
    else if (is_len)    rd_val[4:0] = len_q;
    else if (is_taps)   rd_val[3:0] = taps_q;
    else if (is_sample) rd_val      = sample_mem[bus_addr[SIDX_W-1:0]];
    else if (is_coef)   rd_val      = coef_mem[bus_addr[CIDX_W-1:0]];
    else if (is_result) rd_val      = result_mem[res_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= access;
      bus_rdata <= rd ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_dsp_conv_responder.sv
// ----------------------------------------------------------------------------
// Testbench for dsp_conv_responder. Bus accesses push their expected read
// data into a scoreboard queue; an independent monitor pops and compares on
// every bus_ready pulse. Timing and flag checks are made directly.
// ----------------------------------------------------------------------------
module tb_dsp_conv_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_sel;
  logic        bus_write_en;
  logic [5:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        busy;

  dsp_conv_responder #(
    .DATA_WIDTH (32),
    .MAX_SAMPLES(16),
    .MAX_TAPS   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus_sel     (bus_sel),
    .bus_write_en(bus_write_en),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ready   (bus_ready),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  localparam logic [5:0] A_CTRL = 6'h00, A_STAT = 6'h01, A_LEN = 6'h02, A_TAPS = 6'h03;
  localparam logic [5:0] A_SMP = 6'h10, A_COEF = 6'h20, A_RES = 6'h28;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   busy_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Free-running count of busy cycles; runs are measured as differences.
  always @(negedge clock) if (busy === 1'b1) busy_total++;

  // Monitor: every bus response is compared against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (bus_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", {31'b0, bus_ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(e.name, bus_rdata, e.exp);
      end
    end
  end

  task automatic access(input logic we, input logic [5:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string name);
    exp_t e;
    bit   seen = 1'b0;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(negedge clock);
    bus_sel      = 1'b1;
    bus_write_en = we;
    bus_addr     = addr;
    bus_wdata    = data;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1;
      if (bus_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    bus_sel      = 1'b0;
    bus_write_en = 1'b0;
    if (!seen) begin
      check({name, "_ready_timeout"}, {31'b0, bus_ready}, 32'd1);
      e = sb_q.pop_back();
    end
  endtask

  // Writes always return zero read data.
  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input string name);
    access(1'b1, addr, data, 32'd0, name);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
    access(1'b0, addr, 32'd0, exp, name);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_idle_timeout"}, {31'b0, busy}, 32'd0);
  endtask

  // LEN=4, SAMPLE={1,2,3,4}, TAPS=2, COEF={1,1}
  task automatic load_basic();
    wr(A_LEN, 32'd4, "w_len");
    for (int i = 0; i < 4; i++) wr(A_SMP + 6'(i), 32'(i + 1), "w_smp");
    wr(A_TAPS, 32'd2, "w_taps");
    wr(A_COEF,         32'd1, "w_coef0");
    wr(A_COEF + 6'd1,  32'd1, "w_coef1");
  endtask

  task automatic invalid_start(input string name);
    int b0;
    b0 = busy_total;
    wr(A_CTRL, 32'd1, "w_start_inv");
    repeat (4) @(negedge clock);
    check({name, "_no_busy"}, 32'(busy_total - b0), 32'd0);
    rd(A_STAT, 32'h4, {name, "_status"});
    wr(A_CTRL, 32'd2, "w_clear");
  endtask

  initial begin
    int b0;
    logic [31:0] basic_res [6];
    basic_res = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd4, 32'd0};

    reset        = 1'b1;
    bus_sel      = 1'b0;
    bus_write_en = 1'b0;
    bus_addr     = '0;
    bus_wdata    = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  {31'b0, busy},      32'd0);
    check("rst_ready", {31'b0, bus_ready}, 32'd0);
    check("rst_rdata", bus_rdata,          32'd0);
    reset = 1'b0;
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_LEN,  32'h0, "rst_len");
    rd(A_CTRL, 32'h0, "ctrl_reads_zero");
    wr(6'h05, 32'hDEAD_BEEF, "w_unmapped");
    rd(6'h05, 32'h0, "unmapped_reads_zero");

    // Basic run with busy-protection accesses during it
    load_basic();
    rd(A_TAPS, 32'd2, "taps_readback");
    b0 = busy_total;
    wr(A_CTRL, 32'd1, "w_start");
    rd(A_STAT, 32'h1, "status_running");
    wr(A_SMP, 32'd9, "w_smp_busy");
    rd(A_STAT, 32'h5, "status_busy_err");
    wait_idle("basic");
    check("basic_busy_cycles", 32'(busy_total - b0), 32'd15);
    rd(A_STAT, 32'h6, "status_done_err");
    rd(A_SMP, 32'd1, "smp0_protected");
    for (int i = 0; i < 6; i++) rd(A_RES + 6'(i), basic_res[i], $sformatf("basic_res%0d", i));
    wr(A_CTRL, 32'd2, "w_clear");
    rd(A_STAT, 32'h0, "status_cleared");

    // Invalid starts
    wr(A_LEN, 32'd0, "w_len0");
    invalid_start("inv_len0");
    wr(A_LEN, 32'd17, "w_len17");
    rd(A_LEN, 32'd17, "len17_readback");
    invalid_start("inv_len17");
    wr(A_LEN, 32'd4, "w_len4");
    wr(A_TAPS, 32'd9, "w_taps9");
    invalid_start("inv_taps9");

    // Signed single-tap run: -3 * 5 = -15
    wr(A_LEN,  32'd1, "w_len1");
    wr(A_SMP,  32'hFFFF_FFFD, "w_smp_neg");
    wr(A_TAPS, 32'd1, "w_taps1");
    wr(A_COEF, 32'd5, "w_coef5");
    b0 = busy_total;
    wr(A_CTRL, 32'd1, "w_start_signed");
    wait_idle("signed");
    check("signed_busy_cycles", 32'(busy_total - b0), 32'd2);
    rd(A_RES, 32'hFFFF_FFF1, "signed_res0");
    rd(A_STAT, 32'h2, "signed_status");

    // Overflow: 0x7FFFFFFF * 2
    wr(A_SMP,  32'h7FFF_FFFF, "w_smp_max");
    wr(A_COEF, 32'd2, "w_coef2");
    wr(A_CTRL, 32'd3, "w_clear_start");
    wait_idle("ovf");
`ifdef DSP_CONV_SAT_EN
    rd(A_RES, 32'h7FFF_FFFF, "ovf_res0_sat");
`else
    rd(A_RES, 32'hFFFF_FFFE, "ovf_res0_wrap");
`endif

    // Reset in the middle of a run
    load_basic();
    wr(A_CTRL, 32'd1, "w_start_rst");
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("midrst_busy",  {31'b0, busy},      32'd0);
    check("midrst_ready", {31'b0, bus_ready}, 32'd0);
    reset = 1'b0;
    rd(A_STAT, 32'h0, "midrst_status");
    rd(A_LEN,  32'h0, "midrst_len");
    rd(A_RES,  32'h0, "midrst_res0");
    rd(A_SMP,  32'h0, "midrst_smp0");

    // Fresh run after reset
    load_basic();
    b0 = busy_total;
    wr(A_CTRL, 32'd1, "w_start_fresh");
    wait_idle("fresh");
    check("fresh_busy_cycles", 32'(busy_total - b0), 32'd15);
    rd(A_STAT, 32'h2, "fresh_status");
    for (int i = 0; i < 6; i++) rd(A_RES + 6'(i), basic_res[i], $sformatf("fresh_res%0d", i));

    repeat (4) @(negedge clock);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
